// File: rtl/kbd_pkg.sv
// kbd_pkg: set-2 scancodes, game key bit indices and decoder FSM states
package kbd_pkg;
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    localparam logic [2:0] KEY_LEFT  = 3'd0;
    localparam logic [2:0] KEY_RIGHT = 3'd1;
    localparam logic [2:0] KEY_UP    = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_JUMP  = 3'd4;
    localparam logic [2:0] KEY_START = 3'd5;
    localparam logic [2:0] KEY_PAUSE = 3'd6;
    localparam int KEY_COUNT = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
endpackage

// File: rtl/kbd_keymap.sv
// kbd_keymap: maps a scancode byte plus extended flag to a game key bit index
module kbd_keymap
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [2:0] idx
);
    always_comb begin
        hit = 1'b1;
        idx = KEY_LEFT;
        if (ext) begin
            case (code)
                SC_LEFT:  idx = KEY_LEFT;
                SC_RIGHT: idx = KEY_RIGHT;
                SC_UP:    idx = KEY_UP;
                SC_DOWN:  idx = KEY_DOWN;
                default:  hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_A:     idx = KEY_LEFT;
                SC_D:     idx = KEY_RIGHT;
                SC_W:     idx = KEY_UP;
                SC_S:     idx = KEY_DOWN;
                SC_SPACE: idx = KEY_JUMP;
                SC_ENTER: idx = KEY_START;
                SC_ESC:   idx = KEY_PAUSE;
                default:  hit = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/kbd_decoder.sv
// kbd_decoder: parses PS/2 set-2 make/break/extended sequences into held keys
// and first-make pulses, abandoning stale prefixes after PREFIX_TIMEOUT cycles.
module kbd_decoder
    import kbd_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 100_000,
    parameter int TO_WIDTH       = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          keycode,
    input  logic                 oflag,
    output logic [KEY_COUNT-1:0] key_held,
    output logic [KEY_COUNT-1:0] key_pressed,
    output logic                 seq_error
);
    state_t state, state_n;
    logic [TO_WIDTH-1:0] cnt;
    logic [KEY_COUNT-1:0] held_n;
    logic [7:0] b;
    logic [2:0] idx;
    logic ext, brk, hit, timeout, unused_hi;

    assign b         = keycode[7:0];
    assign unused_hi = ^keycode[15:8];
    assign ext       = state == ST_EXT || state == ST_EXT_BRK;
    assign brk       = state == ST_BRK || state == ST_EXT_BRK;
    assign timeout   = state != ST_IDLE && cnt == TO_WIDTH'(PREFIX_TIMEOUT - 1);

    kbd_keymap u_map (.code(b), .ext(ext), .hit(hit), .idx(idx));

    // E0/F0 always act as prefixes; a byte arriving with the timeout wins
    always_comb begin
        state_n = state;
        held_n  = key_held;
        if (oflag) begin
            if (b == SC_E0) state_n = ST_EXT;
            else if (b == SC_F0) state_n = ext ? ST_EXT_BRK : ST_BRK;
            else begin
                state_n = ST_IDLE;
                if (hit) held_n[idx] = !brk;
            end
        end else if (timeout) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_held    <= '0;
            key_pressed <= '0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= (oflag || timeout || state == ST_IDLE) ? '0 : cnt + 1'b1;
            key_held    <= held_n;
            key_pressed <= held_n & ~key_held;
            seq_error   <= timeout && !oflag;
        end
    end
endmodule
